// File: rtl/ber_monitor.sv
// 16-QAM hard slicer with reference-symbol FIFO and windowed symbol/bit-error counters.
// Closes the AWGN channel loop by comparing sliced RX symbols against the clean TX stream.
module ber_monitor #(
   parameter int unsigned REF_DEPTH = 16,
   parameter int          SLICE_THR = 1295,
   parameter int unsigned CNT_W     = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [11:0] rx_I,
   input  logic signed [11:0] rx_Q,
   input  logic               rx_valid,
   input  logic [3:0]         ref_sym,
   input  logic               ref_valid,
   input  logic               start,
   input  logic [CNT_W-1:0]   measure_len,
   output logic [3:0]         dec_sym,
   output logic               dec_valid,
   output logic [CNT_W-1:0]   sym_count,
   output logic [CNT_W-1:0]   err_count,
   output logic               busy,
   output logic               done,
   output logic               ref_overflow,
   output logic               ref_underflow
);

   localparam int unsigned AW = $clog2(REF_DEPTH);

   typedef enum logic [1:0] {StIdle, StMeasure, StDone} state_e;

   // Signed compares only, so the full [-2048, 2047] range slices without overflow.
   function automatic logic [1:0] slice_axis(input logic signed [11:0] x);
      logic [1:0] b;
      b[1] = (int'(x) < 0);
      b[0] = (int'(x) > -SLICE_THR) && (int'(x) < SLICE_THR);
      return b;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] sym_q, sym_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W:0]   err_sum;

   logic [3:0]       mem [REF_DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q, fill;
   logic             empty, full, pop, push;

   logic [3:0]       dec_sym_q, ref_q, diff;
   logic [2:0]       pop_cnt;
   logic             dec_valid_q, cmp_q;
   logic             ovf_q, unf_q;
   logic             start_ok;

   assign fill     = wr_ptr_q - rd_ptr_q;
   assign empty    = (fill == '0);
   assign full     = (fill == (AW+1)'(REF_DEPTH));
   assign pop      = rx_valid && !empty;
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign push     = ref_valid && (!full || pop);
   assign start_ok = start && (state_q != StMeasure);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= ref_sym;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         dec_sym_q   <= '0;
         dec_valid_q <= 1'b0;
         ref_q       <= '0;
         cmp_q       <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         dec_valid_q <= rx_valid;
         if (rx_valid) begin
            dec_sym_q <= {slice_axis(rx_I), slice_axis(rx_Q)};
            ref_q     <= mem[rd_ptr_q[AW-1:0]];
         end
         // Tag at acceptance so samples taken on the start edge are never counted.
         cmp_q <= pop && (state_q == StMeasure);
         if (start_ok) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end
         if (ref_valid && full && !pop) ovf_q <= 1'b1;
         if (rx_valid && empty)         unf_q <= 1'b1;
      end
   end

   assign diff    = dec_sym_q ^ ref_q;
   assign pop_cnt = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         len_q   <= '0;
         sym_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         sym_q   <= sym_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      sym_d   = sym_q;
      err_d   = err_q;
      err_sum = {1'b0, err_q} + (CNT_W+1)'(pop_cnt);
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               sym_d   = '0;
               err_d   = '0;
               len_d   = measure_len;
               state_d = (measure_len == '0) ? StDone : StMeasure;
            end
         end
         StMeasure: begin
            if (cmp_q) begin
               sym_d = sym_q + CNT_W'(1);
               err_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
               if (sym_d == len_q) state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign dec_sym       = dec_sym_q;
   assign dec_valid     = dec_valid_q;
   assign sym_count     = sym_q;
   assign err_count     = err_q;
   assign busy          = (state_q == StMeasure);
   assign done          = (state_q == StDone);
   assign ref_overflow  = ovf_q;
   assign ref_underflow = unf_q;

endmodule

// File: tb/tb_ber_monitor.sv
// Scoreboard bench for ber_monitor: expected sliced symbols are queued on drive and
// popped on dec_valid; counters and flags are checked at fixed points.
module tb_ber_monitor;

   localparam int unsigned CNT_W = 32;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [11:0] rx_I = '0;
   logic signed [11:0] rx_Q = '0;
   logic               rx_valid = 1'b0;
   logic [3:0]         ref_sym = '0;
   logic               ref_valid = 1'b0;
   logic               start = 1'b0;
   logic [CNT_W-1:0]   measure_len = '0;
   logic [3:0]         dec_sym;
   logic               dec_valid;
   logic [CNT_W-1:0]   sym_count;
   logic [CNT_W-1:0]   err_count;
   logic               busy;
   logic               done;
   logic               ref_overflow;
   logic               ref_underflow;

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] sb [$];

   ber_monitor #(.REF_DEPTH(16), .SLICE_THR(1295), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_I         (rx_I),
      .rx_Q         (rx_Q),
      .rx_valid     (rx_valid),
      .ref_sym      (ref_sym),
      .ref_valid    (ref_valid),
      .start        (start),
      .measure_len  (measure_len),
      .dec_sym      (dec_sym),
      .dec_valid    (dec_valid),
      .sym_count    (sym_count),
      .err_count    (err_count),
      .busy         (busy),
      .done         (done),
      .ref_overflow (ref_overflow),
      .ref_underflow(ref_underflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference slicer written as a region ladder, independent of the RTL form.
   function automatic logic [1:0] m_slice(input int x);
      if (x >= 1295)      return 2'b00;
      else if (x >= 0)    return 2'b01;
      else if (x > -1295) return 2'b11;
      else                return 2'b10;
   endfunction

   function automatic int pt(input logic [1:0] b);
      case (b)
         2'b00:   return 1943;
         2'b01:   return 648;
         2'b11:   return -648;
         default: return -1943;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rx(input int i, input int q);
      rx_I     = 12'(i);
      rx_Q     = 12'(q);
      rx_valid = 1'b1;
      sb.push_back({m_slice(i), m_slice(q)});
   endtask

   task automatic send_rx(input int i, input int q);
      drive_rx(i, q);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_sym(input logic [3:0] s);
      send_rx(pt(s[3:2]), pt(s[1:0]));
   endtask

   task automatic push_ref(input logic [3:0] s);
      ref_sym   = s;
      ref_valid = 1'b1;
      tick();
      ref_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic [CNT_W-1:0] len);
      measure_len = len;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && dec_valid) begin
         if (sb.size() == 0) check_eq("sb_unexpected_dec", 64'd1, 64'd0);
         else                check_eq("dec_sym", 64'(dec_sym), 64'(sb.pop_front()));
      end
   end

   initial begin
      int bnd [8];
      logic [3:0] s;
      bnd = '{1295, 1294, 0, -1, -1294, -1295, -2048, 2047};

      #12;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_sym", 64'(sym_count), 64'd0);
      check_eq("rst_err", 64'(err_count), 64'd0);
      check_eq("rst_dec_valid", 64'(dec_valid), 64'd0);
      rst_n = 1'b1;
      tick();

      // Noise-free loop over all 16 symbols.
      for (int k = 0; k < 16; k++) push_ref(4'(k));
      pulse_start(16);
      check_eq("start_busy", 64'(busy), 64'd1);
      check_eq("start_sym", 64'(sym_count), 64'd0);
      for (int k = 0; k < 16; k++) send_sym(4'(k));
      check_eq("clean_done_early", 64'(done), 64'd0);
      tick();
      check_eq("clean_done", 64'(done), 64'd1);
      check_eq("clean_busy", 64'(busy), 64'd0);
      check_eq("clean_sym", 64'(sym_count), 64'd16);
      check_eq("clean_err", 64'(err_count), 64'd0);
      check_eq("clean_unf", 64'(ref_underflow), 64'd0);

      // Slicer boundaries on each axis (FIFO empty; only dec_sym matters here).
      for (int k = 0; k < 8; k++) send_rx(bnd[k], 648);
      for (int k = 0; k < 8; k++) send_rx(-648, bnd[k]);
      tick();

      // Injected 2-bit errors, with an ignored start mid-window.
      pulse_start(10);
      for (int k = 0; k < 10; k++) push_ref(4'h0);
      for (int k = 0; k < 5; k++) send_rx(648, -1943);
      pulse_start(3);
      check_eq("mid_start_busy", 64'(busy), 64'd1);
      check_eq("mid_start_sym", 64'(sym_count), 64'd5);
      check_eq("mid_start_err", 64'(err_count), 64'd10);
      for (int k = 0; k < 5; k++) send_rx(648, -1943);
      tick();
      check_eq("inj_done", 64'(done), 64'd1);
      check_eq("inj_sym", 64'(sym_count), 64'd10);
      check_eq("inj_err", 64'(err_count), 64'd20);

      // Underflow with a simultaneous push: no bypass, push still lands.
      pulse_start(4);
      check_eq("unf_clear", 64'(ref_underflow), 64'd0);
      ref_sym   = 4'h5;
      ref_valid = 1'b1;
      drive_rx(pt(2'b01), pt(2'b01));
      tick();
      rx_valid  = 1'b0;
      ref_valid = 1'b0;
      tick();
      check_eq("unf_flag", 64'(ref_underflow), 64'd1);
      check_eq("unf_sym", 64'(sym_count), 64'd0);
      send_sym(4'h5);
      tick();
      check_eq("unf_held_sym", 64'(sym_count), 64'd1);
      check_eq("unf_held_err", 64'(err_count), 64'd0);
      check_eq("unf_busy", 64'(busy), 64'd1);

      // Asynchronous reset mid-window.
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_sym", 64'(sym_count), 64'd0);
      check_eq("arst_unf", 64'(ref_underflow), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Overflow: 17th push (0xE) dropped; pops return 1..15, 0.
      for (int k = 1; k <= 16; k++) push_ref(4'(k));
      push_ref(4'hE);
      check_eq("ovf_flag", 64'(ref_overflow), 64'd1);
      check_eq("ovf_unf", 64'(ref_underflow), 64'd0);
      pulse_start(16);
      check_eq("ovf_clear", 64'(ref_overflow), 64'd0);
      for (int k = 1; k <= 16; k++) begin
         s = 4'(k);
         send_sym(s);
      end
      tick();
      check_eq("ovf_sym", 64'(sym_count), 64'd16);
      check_eq("ovf_err", 64'(err_count), 64'd0);
      send_rx(0, 0);
      check_eq("ovf_drained", 64'(ref_underflow), 64'd1);

      // Zero-length window.
      pulse_start(0);
      check_eq("len0_done", 64'(done), 64'd1);
      check_eq("len0_busy", 64'(busy), 64'd0);
      check_eq("len0_sym", 64'(sym_count), 64'd0);

      tick();
      tick();
      check_eq("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
